// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the external bus controller and its wait timer.
package bus_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } bus_state_e;

  // Value returned to the dataflow when a read is abandoned with nothing driving the bus.
  localparam logic [7:0] OPEN_BUS_VALUE = 8'hFF;

endpackage : bus_ctrl_pkg

// File: rtl/bus_wait_timer.sv
// Saturating ACCESS-cycle counter. It flags when the minimum wait has elapsed
// and when the cycle has reached its last permitted ACCESS cycle.
module bus_wait_timer #(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 15
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic enable,
  output logic min_reached,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // With no wait states the unsigned compare would be constant, so it is tied off.
  if (WAIT_STATES == 0) begin : g_no_wait
    assign min_reached = 1'b1;
  end else begin : g_wait
    assign min_reached = (cnt_q >= CNT_W'(WAIT_STATES));
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule : bus_wait_timer

// File: rtl/external_bus_controller.sv
// Runs one external memory cycle per controller request, stretching it through
// ext_ready with a minimum wait and a timeout, and stalling the controller meanwhile.
module external_bus_controller
  import bus_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  addr_low_in,
  input  logic [7:0]  addr_high_in,
  input  logic [7:0]  dor_in,
  input  logic        req_valid,
  input  logic        req_write,
  output logic        cpu_stall,
  output logic [7:0]  read_data_out,
  output logic        bus_error,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_we,
  output logic        ext_re,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ready
);

  bus_state_e  state_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic [7:0]  rdata_q;
  logic        stall_q;
  logic        we_q;
  logic        re_q;
  logic        error_q;

  logic min_reached;
  logic expired;

  bus_wait_timer #(
    .WAIT_STATES (WAIT_STATES),
    .TIMEOUT     (TIMEOUT)
  ) u_wait_timer (
    .clk         (clk),
    .nrst        (nrst),
    .clear       (state_q == IDLE),
    .enable      (state_q == ACCESS),
    .min_reached (min_reached),
    .expired     (expired)
  );

  // NOTE: strobes, stall and error are registered and cleared by the asynchronous
  // reset, so a reset mid-access drops them at once without any bus_error pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      error_q <= 1'b0;
    end else begin
      // NOTE: every state register uses <= so all of them update from the same
      // pre-edge values; a blocking write here would leak into later statements.
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= {addr_high_in, addr_low_in};
            wdata_q <= dor_in;
            write_q <= req_write;
            stall_q <= 1'b1;
            we_q    <= req_write;
            re_q    <= ~req_write;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // Completion is tested first so it wins over a same-edge timeout.
          if (min_reached && ext_ready) begin
            if (!write_q) rdata_q <= ext_rdata;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            state_q <= IDLE;
          end else if (expired) begin
            if (!write_q) rdata_q <= OPEN_BUS_VALUE;
            error_q <= 1'b1;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_stall     = stall_q;
  assign read_data_out = rdata_q;
  assign bus_error     = error_q;
  assign ext_addr      = addr_q;
  assign ext_wdata     = wdata_q;
  assign ext_we        = we_q;
  assign ext_re        = re_q;

endmodule : external_bus_controller

// File: tb/tb_external_bus_controller.sv
// Directed bench: three controllers with 0, 2 and 3 wait states share stimulus;
// sel chooses which one receives the request and is observed.
module tb_external_bus_controller;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  addr_hi, addr_lo, dor, ext_rdata;
  logic        req, req_write, ext_ready;
  int          sel;

  logic        rv    [3];
  logic        stall [3];
  logic        err   [3];
  logic        we    [3];
  logic        re    [3];
  logic [7:0]  rd    [3];
  logic [7:0]  wd    [3];
  logic [15:0] ea    [3];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rv[g] = req && (sel == g);
    external_bus_controller #(
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
      .TIMEOUT     (15)
    ) u_dut (
      .clk           (clk),
      .nrst          (nrst),
      .addr_low_in   (addr_lo),
      .addr_high_in  (addr_hi),
      .dor_in        (dor),
      .req_valid     (rv[g]),
      .req_write     (req_write),
      .cpu_stall     (stall[g]),
      .read_data_out (rd[g]),
      .bus_error     (err[g]),
      .ext_addr      (ea[g]),
      .ext_wdata     (wd[g]),
      .ext_we        (we[g]),
      .ext_re        (re[g]),
      .ext_rdata     (ext_rdata),
      .ext_ready     (ext_ready)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge, where inputs change and outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] d);
    addr_hi   = hi;
    addr_lo   = lo;
    dor       = d;
    req_write = w;
    req       = 1'b1;
    step();
    req       = 1'b0;
  endtask

  // Counts ACCESS cycles of the selected DUT; raises ext_ready on cycle ready_at (0 = never).
  task automatic run_access(input string tag, input logic w, input int ready_at, output int n);
    logic bad_strobe;
    logic early_err;
    n = 0;
    bad_strobe = 1'b0;
    early_err  = 1'b0;
    while (stall[sel] && n < 40) begin
      n++;
      if (we[sel] !== w || re[sel] !== ~w) bad_strobe = 1'b1;
      if (err[sel] !== 1'b0) early_err = 1'b1;
      if (n == ready_at) ext_ready = 1'b1;
      step();
    end
    check({tag, "_strobes"}, {31'd0, bad_strobe}, 32'd0);
    check({tag, "_err_in_access"}, {31'd0, early_err}, 32'd0);
  endtask

  initial begin
    int n;
    nrst = 1'b0; req = 1'b0; req_write = 1'b0; ext_ready = 1'b0; sel = 0;
    addr_hi = '0; addr_lo = '0; dor = '0; ext_rdata = '0;
    repeat (3) step();
    check("rst_stall", {31'd0, stall[0]}, 32'd0);
    check("rst_rdata", {24'd0, rd[0]}, 32'h00);
    check("rst_err",   {31'd0, err[0]}, 32'd0);
    check("rst_strb",  {30'd0, we[0], re[0]}, 32'd0);
    check("rst_addr",  {16'd0, ea[0]}, 32'h0000);
    @(negedge clk) nrst = 1'b1;
    step();

    // Reset mid-read on the 2-wait DUT with memory never ready.
    sel = 1; ext_ready = 1'b0;
    issue(1'b0, 8'h40, 8'h01, 8'h00);
    step();
    check("mrst_stall_before", {31'd0, stall[1]}, 32'd1);
    #3 nrst = 1'b0;
    #1;
    check("mrst_stall", {31'd0, stall[1]}, 32'd0);
    check("mrst_re",    {31'd0, re[1]}, 32'd0);
    check("mrst_rdata", {24'd0, rd[1]}, 32'h00);
    check("mrst_err",   {31'd0, err[1]}, 32'd0);
    @(negedge clk) nrst = 1'b1;
    step();
    check("mrst_err_after", {31'd0, err[1]}, 32'd0);
    ext_ready = 1'b1; ext_rdata = 8'h66;
    issue(1'b0, 8'h40, 8'h02, 8'h00);
    run_access("mrst_next", 1'b0, 0, n);
    check("mrst_next_len",   n, 3);
    check("mrst_next_rdata", {24'd0, rd[1]}, 32'h66);

    // 2-wait write, ready tied high, dor changes mid-cycle.
    issue(1'b1, 8'h20, 8'h08, 8'h5C);
    dor = 8'h77;
    check("wr_wdata_first", {24'd0, wd[1]}, 32'h5C);
    run_access("wr", 1'b1, 0, n);
    check("wr_len",   n, 3);
    check("wr_wdata", {24'd0, wd[1]}, 32'h5C);
    check("wr_rdata_kept", {24'd0, rd[1]}, 32'h66);
    check("wr_addr_held",  {16'd0, ea[1]}, 32'h2008);

    // 0-wait read with ready already high.
    sel = 0; ext_ready = 1'b1; ext_rdata = 8'hA5;
    issue(1'b0, 8'h12, 8'h34, 8'h00);
    check("r0_addr",  {16'd0, ea[0]}, 32'h1234);
    check("r0_re",    {31'd0, re[0]}, 32'd1);
    check("r0_stall", {31'd0, stall[0]}, 32'd1);
    run_access("r0", 1'b0, 0, n);
    check("r0_len",   n, 1);
    check("r0_rdata", {24'd0, rd[0]}, 32'hA5);

    // Slow read: ready rises on the 5th ACCESS cycle.
    ext_ready = 1'b0; ext_rdata = 8'h3C;
    issue(1'b0, 8'h55, 8'h66, 8'h00);
    run_access("slow", 1'b0, 5, n);
    check("slow_len",   n, 5);
    check("slow_rdata", {24'd0, rd[0]}, 32'h3C);
    check("slow_err",   {31'd0, err[0]}, 32'd0);

    // Timed-out read returns the open-bus value with one error pulse.
    ext_ready = 1'b0; ext_rdata = 8'h11;
    issue(1'b0, 8'hDE, 8'hAD, 8'h00);
    run_access("to_rd", 1'b0, 0, n);
    check("to_rd_len",   n, 15);
    check("to_rd_err",   {31'd0, err[0]}, 32'd1);
    check("to_rd_rdata", {24'd0, rd[0]}, 32'hFF);
    step();
    check("to_rd_err_pulse", {31'd0, err[0]}, 32'd0);

    // Seed read data, then a timed-out write must leave it alone.
    ext_ready = 1'b1; ext_rdata = 8'h5A;
    issue(1'b0, 8'h00, 8'h10, 8'h00);
    run_access("seed", 1'b0, 0, n);
    check("seed_rdata", {24'd0, rd[0]}, 32'h5A);
    ext_ready = 1'b0;
    issue(1'b1, 8'hBE, 8'hEF, 8'h99);
    run_access("to_wr", 1'b1, 0, n);
    check("to_wr_len",   n, 15);
    check("to_wr_err",   {31'd0, err[0]}, 32'd1);
    check("to_wr_rdata", {24'd0, rd[0]}, 32'h5A);
    step();
    check("to_wr_err_pulse", {31'd0, err[0]}, 32'd0);

    // 3-wait DUT: early ready is ignored; back-to-back request in first IDLE cycle.
    sel = 2; ext_ready = 1'b1; ext_rdata = 8'hC3;
    issue(1'b0, 8'hAA, 8'h01, 8'h00);
    run_access("early", 1'b0, 0, n);
    check("early_len",   n, 4);
    check("early_rdata", {24'd0, rd[2]}, 32'hC3);
    ext_rdata = 8'h3E;
    issue(1'b0, 8'hAA, 8'h02, 8'h00);
    check("b2b_stall", {31'd0, stall[2]}, 32'd1);
    check("b2b_addr",  {16'd0, ea[2]}, 32'hAA02);
    run_access("b2b", 1'b0, 0, n);
    check("b2b_len",   n, 4);
    check("b2b_rdata", {24'd0, rd[2]}, 32'h3E);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_external_bus_controller
